// File: rtl/gyro_integrator.sv
// gyro_integrator: turns raw signed angular-rate samples into wrapped
// pitch/roll/yaw angles in whole degrees (0-359).
// Data path: fixed-rate sampling, startup zero-rate bias calibration,
// deadband, then integration with an exact fractional-degree remainder.
// Handshake: valid_out is a one-cycle pulse on every edge that commits new
// angles; there is no back-pressure. Inputs are level-sampled on tick edges.
module gyro_integrator #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int CAL_LOG2      = 8,
  parameter int DEADBAND      = 40,
  parameter int UNITS_PER_DEG = 131000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [15:0] gx,
  input  logic signed [15:0] gy,
  input  logic signed [15:0] gz,
  input  logic               zero_in,
  input  logic               recal_in,
  output logic [8:0]         pitch,
  output logic [8:0]         roll,
  output logic [8:0]         yaw,
  output logic               valid_out,
  output logic               calibrating_out,
  output logic               dbg_state_out
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int SW = 16 + CAL_LOG2;
  // Remainder plus one signed 17-bit rate must fit: UNITS_PER_DEG > 65535
  // means two extra bits over the remainder range are enough.
  localparam int FW = $clog2(UNITS_PER_DEG) + 2;

  localparam logic [CW-1:0]         TICK_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CAL_LOG2-1:0]   CAL_LAST  = '1;
  localparam logic signed [16:0]    DB_P      = 17'(DEADBAND);
  localparam logic signed [16:0]    DB_N      = -DB_P;
  localparam logic signed [FW-1:0]  UPD       = FW'(UNITS_PER_DEG);
  localparam logic [8:0]            DEG_MAX   = 9'd359;

  typedef enum logic {
    ST_CAL = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_cal_done;
  logic                  w_capture;
  logic                  w_zero;
  logic                  w_commit;

  logic [CW-1:0]         r_tick_cnt;
  logic                  w_tick;
  logic [CAL_LOG2-1:0]   r_cal_cnt;

  logic signed [15:0]    w_in       [3];
  logic signed [SW-1:0]  r_sum      [3];
  logic signed [SW-1:0]  w_sum_add  [3];
  logic signed [SW-1:0]  w_bias_full[3];
  logic signed [15:0]    r_bias     [3];

  logic                  r_s1_vld;
  logic signed [15:0]    r_raw      [3];
  logic                  r_s2_vld;
  logic signed [16:0]    w_diff     [3];
  logic signed [16:0]    w_d_db     [3];
  logic signed [16:0]    r_d        [3];

  logic signed [FW-1:0]  w_f        [3];
  logic signed [FW-1:0]  w_frac_nxt [3];
  logic [8:0]            w_deg_nxt  [3];
  logic signed [FW-1:0]  r_frac     [3];
  logic [8:0]            r_deg      [3];
  logic                  r_valid;

  assign w_in[0] = gx;
  assign w_in[1] = gy;
  assign w_in[2] = gz;
  assign w_tick  = (r_tick_cnt == TICK_LAST);

  // Free-running sample-rate counter; nothing but reset touches it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_CAL;
    else r_state <= w_state_nxt;
  end

  // Next state and pipeline control; recal_in overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cal_done  = 1'b0;
    w_capture   = 1'b0;
    w_zero      = 1'b0;
    if (recal_in) begin
      w_state_nxt = ST_CAL;
    end else if (r_state == ST_CAL) begin
      if (w_tick && (r_cal_cnt == CAL_LAST)) begin
        w_state_nxt = ST_RUN;
        w_cal_done  = 1'b1;
      end
    end else begin
      w_capture = w_tick;
      w_zero    = zero_in;
    end
    w_commit = r_s2_vld && !recal_in && !w_zero;
  end

  // Calibration sums and the bias they produce (floor average).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sum_add[i]   = r_sum[i] + SW'(w_in[i]);
      w_bias_full[i] = w_sum_add[i] >>> CAL_LOG2;
    end
  end

  // Accumulate during CAL; on the last calibration tick latch the bias.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cal_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        r_sum[i]  <= '0;
        r_bias[i] <= '0;
      end
    end else if (recal_in) begin
      r_cal_cnt <= '0;
      for (int i = 0; i < 3; i++) r_sum[i] <= '0;
    end else if ((r_state == ST_CAL) && w_tick) begin
      if (w_cal_done) begin
        r_cal_cnt <= '0;
        for (int i = 0; i < 3; i++) begin
          r_sum[i]  <= '0;
          r_bias[i] <= w_bias_full[i][15:0];
        end
      end else begin
        r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
        for (int i = 0; i < 3; i++) r_sum[i] <= w_sum_add[i];
      end
    end
  end

  // Bias removal and deadband for the S2 stage.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_diff[i] = 17'(r_raw[i]) - 17'(r_bias[i]);
      if ((w_diff[i] <= DB_P) && (w_diff[i] >= DB_N)) w_d_db[i] = '0;
      else w_d_db[i] = w_diff[i];
    end
  end

  // S1 capture and S2 bias-corrected rate; recal_in flushes both.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_raw[i] <= '0;
        r_d[i]   <= '0;
      end
    end else begin
      r_s1_vld <= w_capture;
      r_s2_vld <= r_s1_vld && !recal_in;
      for (int i = 0; i < 3; i++) begin
        if (w_capture) r_raw[i] <= w_in[i];
        if (r_s1_vld) r_d[i] <= w_d_db[i];
      end
    end
  end

  // S3 arithmetic: add the rate into the remainder, step at most one degree.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_f[i]        = r_frac[i] + FW'(r_d[i]);
      w_frac_nxt[i] = w_f[i];
      w_deg_nxt[i]  = r_deg[i];
      if (w_f[i] >= UPD) begin
        w_frac_nxt[i] = w_f[i] - UPD;
        w_deg_nxt[i]  = (r_deg[i] == DEG_MAX) ? 9'd0 : r_deg[i] + 9'd1;
      end else if (w_f[i][FW-1]) begin
        w_frac_nxt[i] = w_f[i] + UPD;
        w_deg_nxt[i]  = (r_deg[i] == 9'd0) ? DEG_MAX : r_deg[i] - 9'd1;
      end
    end
  end

  // S3 commit; zero_in wins over a commit on the same edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_deg[i]  <= '0;
        r_frac[i] <= '0;
      end
    end else begin
      r_valid <= w_commit;
      for (int i = 0; i < 3; i++) begin
        if (w_zero) begin
          r_deg[i]  <= '0;
          r_frac[i] <= '0;
        end else if (w_commit) begin
          r_deg[i]  <= w_deg_nxt[i];
          r_frac[i] <= w_frac_nxt[i];
        end
      end
    end
  end

  assign pitch           = r_deg[0];
  assign roll            = r_deg[1];
  assign yaw             = r_deg[2];
  assign valid_out       = r_valid;
  assign calibrating_out = (r_state == ST_CAL);
  assign dbg_state_out   = (r_state == ST_RUN);

endmodule

// File: tb/tb_gyro_integrator.sv
// tb_gyro_integrator: directed scenarios for gyro_integrator with
// SAMPLE_PERIOD=4 and CAL_LOG2=2; expected values are hand-computed.
module tb_gyro_integrator;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic signed [15:0] gx = '0;
  logic signed [15:0] gy = '0;
  logic signed [15:0] gz = '0;
  logic               zero_in = 1'b0;
  logic               recal_in = 1'b0;
  logic [8:0]         pitch, roll, yaw;
  logic               valid_out, calibrating_out, dbg_state_out;

  int checks = 0;
  int failures = 0;

  // Independent sample-tick model: a tick edge leaves this at 0.
  logic [1:0] m_cnt;

  gyro_integrator #(
    .SAMPLE_PERIOD(4), .CAL_LOG2(2), .DEADBAND(40), .UNITS_PER_DEG(131000)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .gx(gx), .gy(gy), .gz(gz),
    .zero_in(zero_in), .recal_in(recal_in),
    .pitch(pitch), .roll(roll), .yaw(yaw),
    .valid_out(valid_out), .calibrating_out(calibrating_out),
    .dbg_state_out(dbg_state_out)
  );

  // Clock generation.
  always #5 clk_in = ~clk_in;

  // Tick model.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) m_cnt <= 2'd0;
    else m_cnt <= m_cnt + 2'd1;
  end

  task automatic apply_reset();
    rst_in = 1'b1; zero_in = 1'b0; recal_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  // Returns 1 time unit after the next tick edge.
  task automatic next_tick();
    int n = 0;
    do begin
      @(posedge clk_in); #1; n++;
    end while (m_cnt != 2'd0 && n < 16);
    if (m_cnt != 2'd0) begin
      checks++; failures++;
      $display("FAIL tick_timeout: got no tick within %0d cycles", n);
    end
  endtask

  task automatic two_edges();
    repeat (2) begin @(posedge clk_in); #1; end
  endtask

  task automatic calibrate_zero();
    gx = '0; gy = '0; gz = '0;
    apply_reset();
    repeat (4) next_tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; gx = 16'sd500; gz = 16'sd700;
    repeat (2) @(posedge clk_in); #1;
    checks++; if ({pitch, roll, yaw} !== 27'd0) begin failures++;
      $display("FAIL reset_angles: got %0d/%0d/%0d, expected 0/0/0", pitch, roll, yaw); end
    checks++; if (valid_out !== 1'b0) begin failures++;
      $display("FAIL reset_valid: got %0b, expected 0", valid_out); end
    checks++; if (calibrating_out !== 1'b1 || dbg_state_out !== 1'b0) begin failures++;
      $display("FAIL reset_cal: got cal=%0b st=%0b, expected cal=1 st=0", calibrating_out, dbg_state_out); end
    checks++; if (dut.r_frac[2] !== 19'sd0) begin failures++;
      $display("FAIL reset_frac: got %0d, expected 0", dut.r_frac[2]); end
  endtask

  task automatic test_calibration();
    int bad_valid = 0;
    int bad_angle = 0;
    gx = 16'sd100; gy = -16'sd50; gz = -16'sd3;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      next_tick();
      checks++; if (calibrating_out !== (k < 4)) begin failures++;
        $display("FAIL cal_flag_tick%0d: got %0b, expected %0b", k, calibrating_out, k < 4); end
    end
    checks++; if (dut.r_bias[0] !== 16'sd100) begin failures++;
      $display("FAIL bias_x: got %0d, expected 100", dut.r_bias[0]); end
    checks++; if (dut.r_bias[1] !== -16'sd50) begin failures++;
      $display("FAIL bias_y: got %0d, expected -50", dut.r_bias[1]); end
    checks++; if (dut.r_bias[2] !== -16'sd3) begin failures++;
      $display("FAIL bias_z: got %0d, expected -3", dut.r_bias[2]); end
    for (int k = 0; k < 20; k++) begin
      next_tick();
      @(posedge clk_in); #1;
      if (valid_out !== 1'b0) bad_valid++;
      @(posedge clk_in); #1;
      if (valid_out !== 1'b1) bad_valid++;
      if ({pitch, roll, yaw} !== 27'd0) bad_angle++;
    end
    checks++; if (bad_valid != 0) begin failures++;
      $display("FAIL cal_valid_timing: got %0d bad samples, expected 0", bad_valid); end
    checks++; if (bad_angle != 0) begin failures++;
      $display("FAIL cal_angles_hold: got %0d nonzero samples, expected 0", bad_angle); end
  endtask

  task automatic test_integration();
    calibrate_zero();
    gz = 16'sd13100;
    for (int k = 1; k <= 10; k++) begin
      next_tick();
      two_edges();
      checks++; if (yaw !== ((k == 10) ? 9'd1 : 9'd0)) begin failures++;
        $display("FAIL integ_yaw_commit%0d: got %0d, expected %0d", k, yaw, (k == 10)); end
      checks++; if (dut.r_frac[2] !== ((k == 10) ? 19'sd0 : 19'(13100 * k))) begin failures++;
        $display("FAIL integ_frac_commit%0d: got %0d", k, dut.r_frac[2]); end
    end
  endtask

  task automatic test_negative_wrap();
    calibrate_zero();
    gz = 16'sh8000;
    next_tick();
    two_edges();
    checks++; if (yaw !== 9'd359) begin failures++;
      $display("FAIL negwrap_yaw1: got %0d, expected 359", yaw); end
    checks++; if (dut.r_frac[2] !== 19'sd98232) begin failures++;
      $display("FAIL negwrap_frac1: got %0d, expected 98232", dut.r_frac[2]); end
    repeat (4) next_tick();
    gz = '0;
    two_edges();
    // 5 x 32768 below zero: two borrows, 2*131000 - 163840 = 98160 left.
    checks++; if (yaw !== 9'd358) begin failures++;
      $display("FAIL negwrap_yaw5: got %0d, expected 358", yaw); end
    checks++; if (dut.r_frac[2] !== 19'sd98160) begin failures++;
      $display("FAIL negwrap_frac5: got %0d, expected 98160", dut.r_frac[2]); end
  endtask

  task automatic test_deadband();
    calibrate_zero();
    gx = 16'sd40;
    repeat (50) next_tick();
    gx = 16'sd41;
    two_edges();
    checks++; if (pitch !== 9'd0 || dut.r_frac[0] !== 19'sd0) begin failures++;
      $display("FAIL deadband_40: got pitch=%0d frac=%0d, expected 0/0", pitch, dut.r_frac[0]); end
    next_tick();
    gx = -16'sd40;
    two_edges();
    checks++; if (dut.r_frac[0] !== 19'sd41) begin failures++;
      $display("FAIL deadband_41: got %0d, expected 41", dut.r_frac[0]); end
    next_tick();
    gx = -16'sd41;
    two_edges();
    checks++; if (dut.r_frac[0] !== 19'sd41 || pitch !== 9'd0) begin failures++;
      $display("FAIL deadband_m40: got frac=%0d pitch=%0d, expected 41/0", dut.r_frac[0], pitch); end
    next_tick();
    gx = '0;
    two_edges();
    checks++; if (dut.r_frac[0] !== 19'sd0 || pitch !== 9'd0) begin failures++;
      $display("FAIL deadband_m41: got frac=%0d pitch=%0d, expected 0/0", dut.r_frac[0], pitch); end
  endtask

  task automatic test_zero_coincident();
    calibrate_zero();
    gz = 16'sd32767;
    repeat (4) next_tick();
    gz = 16'sd13100;
    two_edges();
    checks++; if (yaw !== 9'd1 || dut.r_frac[2] !== 19'sd68) begin failures++;
      $display("FAIL zero_pre: got yaw=%0d frac=%0d, expected 1/68", yaw, dut.r_frac[2]); end
    next_tick();
    @(posedge clk_in); #1;
    zero_in = 1'b1;
    @(posedge clk_in); #1;
    zero_in = 1'b0;
    checks++; if ({pitch, roll, yaw} !== 27'd0 || dut.r_frac[2] !== 19'sd0) begin failures++;
      $display("FAIL zero_clear: got yaw=%0d frac=%0d, expected 0/0", yaw, dut.r_frac[2]); end
    checks++; if (valid_out !== 1'b0) begin failures++;
      $display("FAIL zero_valid: got %0b, expected 0", valid_out); end
    next_tick();
    two_edges();
    checks++; if (valid_out !== 1'b1 || yaw !== 9'd0 || dut.r_frac[2] !== 19'sd13100) begin failures++;
      $display("FAIL zero_next: got v=%0b yaw=%0d frac=%0d, expected 1/0/13100", valid_out, yaw, dut.r_frac[2]); end
  endtask

  task automatic test_recal_and_reset();
    int nvalid = 0;
    int n = 0;
    calibrate_zero();
    gz = 16'sd32767;
    repeat (4) next_tick();
    two_edges();
    next_tick();
    gz = '0;
    @(posedge clk_in); #1;
    recal_in = 1'b1; zero_in = 1'b1;
    @(posedge clk_in); #1;
    checks++; if (valid_out !== 1'b0 || calibrating_out !== 1'b1) begin failures++;
      $display("FAIL recal_flush: got v=%0b cal=%0b, expected 0/1", valid_out, calibrating_out); end
    checks++; if (yaw !== 9'd1 || dut.r_frac[2] !== 19'sd68) begin failures++;
      $display("FAIL recal_hold: got yaw=%0d frac=%0d, expected 1/68", yaw, dut.r_frac[2]); end
    repeat (5) begin @(posedge clk_in); #1; if (valid_out) nvalid++; end
    recal_in = 1'b0; zero_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n = 0;
      do begin
        @(posedge clk_in); #1; n++;
        if (valid_out) nvalid++;
      end while (m_cnt != 2'd0 && n < 16);
      checks++; if (calibrating_out !== (k < 4)) begin failures++;
        $display("FAIL recal_cal_tick%0d: got %0b, expected %0b", k, calibrating_out, k < 4); end
    end
    checks++; if (nvalid != 0 || yaw !== 9'd1) begin failures++;
      $display("FAIL recal_quiet: got %0d pulses yaw=%0d, expected 0/1", nvalid, yaw); end
    gz = 16'sd32767;
    next_tick();
    @(posedge clk_in); #4;
    rst_in = 1'b1;
    #1;
    checks++; if ({pitch, roll, yaw} !== 27'd0 || valid_out !== 1'b0) begin failures++;
      $display("FAIL async_rst_out: got yaw=%0d v=%0b, expected 0/0", yaw, valid_out); end
    checks++; if (calibrating_out !== 1'b1 || dut.r_frac[2] !== 19'sd0) begin failures++;
      $display("FAIL async_rst_cal: got cal=%0b frac=%0d, expected 1/0", calibrating_out, dut.r_frac[2]); end
    apply_reset();
    two_edges();
    checks++; if (valid_out !== 1'b0 || yaw !== 9'd0) begin failures++;
      $display("FAIL async_rst_flush: got v=%0b yaw=%0d, expected 0/0", valid_out, yaw); end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_integration();
    test_negative_wrap();
    test_deadband();
    test_zero_coincident();
    test_recal_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
